// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester APB master sequencer sharing one zero-wait-state slave
// Optional feature macro: APB_ARB_FIXED_PRIO_EN (requester 0 always wins contention).
module apb_req_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [31:0]           paddr,
    output logic [31:0]           pwdata,
    input  logic [31:0]           prdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ACCESS  = 3'd2,
        S_WAIT_RD = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q;
    logic                gnt;
    logic                accept;
    logic                pwrite_q;
    logic [31:0]         paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   wdata_sel;

    assign accept = (state_q == S_IDLE) && (|req_valid);

`ifdef APB_ARB_FIXED_PRIO_EN
    assign gnt = ~req_valid[0];
`else
    logic last_grant_q;

    // Under contention the requester that did not win last time goes first.
    assign gnt = (&req_valid) ? ~last_grant_q : req_valid[1];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= gnt;
        end
    end
`endif

    assign addr_sel  = gnt ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
    assign wdata_sel = gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        psel      = 1'b0;
        penable   = 1'b0;
        done      = 2'b00;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    req_ready = gnt ? 2'b10 : 2'b01;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                psel    = 1'b1;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                state_d = pwrite_q ? S_RESP : S_WAIT_RD;
            end
            S_WAIT_RD: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                done    = owner_q ? 2'b10 : 2'b01;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Command fields stay on the bus after completion until the next accept.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            owner_q  <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= 32'h0;
            pwdata_q <= '0;
        end else if (accept) begin
            owner_q  <= gnt;
            pwrite_q <= req_write[gnt];
            paddr_q  <= {{(32-ADDR_W){1'b0}}, addr_sel};
            pwdata_q <= wdata_sel;
        end
    end

    // The slave registers prdata, so it is only valid one cycle after ACCESS.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rdata_q <= '0;
        end else if (state_q == S_WAIT_RD) begin
            rdata_q <= prdata;
        end
    end

    assign pwrite = pwrite_q;
    assign paddr  = paddr_q;
    assign pwdata = pwdata_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - self-checking bench for apb_req_arbiter
module tb_apb_req_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic                 pclk = 1'b0;
    logic                 presetn = 1'b0;
    logic [1:0]           req_valid, req_write;
    logic [2*ADDR_W-1:0]  req_addr;
    logic [2*DATA_W-1:0]  req_wdata;
    logic [1:0]           req_ready, done;
    logic [DATA_W-1:0]    rdata;
    logic                 busy, psel, penable, pwrite;
    logic [31:0]          paddr, pwdata, prdata;

    apb_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .done(done), .rdata(rdata), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    logic [31:0] smem [logic [31:0]];
    always @(posedge pclk) begin
        if (psel && penable) begin
            if (pwrite) smem[paddr] = pwdata;
            else        prdata <= smem.exists(paddr) ? smem[paddr] : 32'h0;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [1:0] oh(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [7:0] a0,
                         input logic [7:0] a1, input logic [31:0] d0, input logic [31:0] d1);
        req_valid = v;
        req_write = w;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    typedef struct {
        logic        id;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] last_rd = 32'h0;

    task automatic run_cmd(input vec_t t);
        logic [1:0] m;
        int pulse, fin;
        m = oh(t.id);
        pulse = t.wr ? 3 : 4;
        fin   = t.wr ? 4 : 5;
        drive(m, {t.wr, t.wr}, t.addr, t.addr, t.wdata, t.wdata);
        @(negedge pclk);
        chk("tbl_ready", req_ready, m);
        chk("tbl_idle_busy", busy, 0);
        @(posedge pclk); #1;
        drive(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0);
        for (int k = 1; k <= fin; k++) begin
            @(negedge pclk);
            if (!t.wr && k >= pulse) last_rd = t.exp_rd;
            chk("tbl_psel", psel, (k == 1 || k == 2));
            chk("tbl_penable", penable, (k == 2));
            chk("tbl_done", done, (k == pulse) ? m : 2'b00);
            chk("tbl_busy", busy, (k < fin));
            chk("tbl_paddr", paddr, {24'h0, t.addr});
            chk("tbl_pwrite", pwrite, t.wr);
            if (t.wr) chk("tbl_pwdata", pwdata, t.wdata);
            chk("tbl_rdata", rdata, last_rd);
            @(posedge pclk); #1;
        end
    endtask

    // Reference model: transaction timeline counted from the accept edge.
    int          m_tl = 0;
    logic        m_wr = 1'b0, m_g = 1'b0, m_lg = 1'b1;
    logic [7:0]  m_addr = 8'h0;
    logic [31:0] m_wdata = 32'h0, m_rd_val = 32'h0, exp_rdata = 32'h0;
    logic [31:0] mmem [logic [7:0]];

    task automatic rstep(output bit acc, output bit g);
        logic [1:0]  v, w;
        logic [15:0] a;
        logic [63:0] d;
        int pulse, fin;
        @(negedge pclk);
        v = req_valid; w = req_write; a = req_addr; d = req_wdata;
        pulse = m_wr ? 3 : 4;
        fin   = m_wr ? 4 : 5;
        acc = (m_tl == 0) && (v != 2'b00);
`ifdef APB_ARB_FIXED_PRIO_EN
        if (v[0]) g = 1'b0; else g = 1'b1;
`else
        if (v == 2'b11) g = !m_lg; else g = v[1];
`endif
        chk("rnd_ready", req_ready, acc ? oh(g) : 2'b00);
        chk("rnd_busy", busy, (m_tl != 0));
        chk("rnd_psel", psel, (m_tl == 1 || m_tl == 2));
        chk("rnd_penable", penable, (m_tl == 2));
        chk("rnd_done", done, (m_tl == pulse) ? oh(m_g) : 2'b00);
        chk("rnd_paddr", paddr, {24'h0, m_addr});
        chk("rnd_pwdata", pwdata, m_wdata);
        chk("rnd_pwrite", pwrite, m_wr);
        chk("rnd_rdata", rdata, exp_rdata);
        @(posedge pclk); #1;
        if (acc) begin
            m_tl = 1; m_g = g; m_lg = g;
            m_wr = w[g];
            m_addr  = g ? a[15:8] : a[7:0];
            m_wdata = g ? d[63:32] : d[31:0];
            if (m_wr) mmem[m_addr] = m_wdata;
            else m_rd_val = mmem.exists(m_addr) ? mmem[m_addr] : 32'h0;
        end else if (m_tl != 0) begin
            m_tl++;
            if (!m_wr && m_tl == 4) exp_rdata = m_rd_val;
            if (m_tl == fin) m_tl = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          acc, g;
        bit          pend [2];
        logic        cw [2];
        logic [7:0]  ca [2];
        logic [31:0] cd [2];
        bit          gr [$];
        int          last_c;
        bit          chk_pw;
        bit          pw_g;

        tbl[0] = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b1, 8'h20, 32'h12345678, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 8'h20, 32'h0,        32'h12345678};
        tbl[4] = '{1'b1, 1'b1, 8'hFC, 32'hFFFFFFFF, 32'h0};
        tbl[5] = '{1'b0, 1'b0, 8'hFC, 32'h0,        32'hFFFFFFFF};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 32'h00000000, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 32'h0,        32'h00000000};
        tbl[8] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};

        drive(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0);
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;

        foreach (tbl[i]) run_cmd(tbl[i]);

        // Reset during the ACCESS phase of a read.
        drive(2'b10, 2'b00, 8'h0, 8'h10, 32'h0, 32'h0);
        @(negedge pclk);
        chk("rstx_ready", req_ready, 2'b10);
        @(posedge pclk); #1;
        drive(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0);
        @(posedge pclk); #1;
        chk("rstx_access_psel", psel, 1);
        chk("rstx_access_penable", penable, 1);
        presetn = 1'b0;
        #1;
        chk("rstx_psel", psel, 0);
        chk("rstx_penable", penable, 0);
        chk("rstx_busy", busy, 0);
        chk("rstx_done", done, 0);
        chk("rstx_rdata", rdata, 0);
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge pclk);
            chk("rstx_no_done", done, 0);
            chk("rstx_idle", busy, 0);
        end

        // Continuous contention with writes.
        @(posedge pclk); #1;
        drive(2'b11, 2'b11, 8'h30, 8'h34, 32'hA, 32'hB);
        last_c = -1;
        chk_pw = 1'b0;
        pw_g = 1'b0;
        for (int c = 0; c < 40 && gr.size() < 4; c++) begin
            @(negedge pclk);
            if (chk_pw) begin
                chk("cont_pwdata", pwdata, pw_g ? 32'hB : 32'hA);
                chk_pw = 1'b0;
            end
            if (busy) begin
                chk("cont_busy_ready", req_ready, 2'b00);
            end else begin
                chk("cont_ready_onehot", (req_ready == 2'b01 || req_ready == 2'b10), 1);
                gr.push_back(req_ready[1]);
                pw_g = req_ready[1];
                chk_pw = 1'b1;
                if (last_c >= 0) chk("cont_gap", c - last_c, 4);
                last_c = c;
            end
        end
        @(negedge pclk);
        if (chk_pw) chk("cont_pwdata", pwdata, pw_g ? 32'hB : 32'hA);
        chk("cont_grant_count", gr.size(), 4);
        foreach (gr[i]) begin
`ifdef APB_ARB_FIXED_PRIO_EN
            chk("cont_grant", gr[i], 0);
`else
            chk("cont_grant", gr[i], i % 2);
`endif
        end
        @(posedge pclk); #1;
        drive(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0);
        repeat (6) @(posedge pclk);

        // Randomized traffic against the reference model, from a fresh reset.
        #1 presetn = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        m_tl = 0; m_wr = 1'b0; m_g = 1'b0; m_lg = 1'b1;
        m_addr = 8'h0; m_wdata = 32'h0; exp_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; cw[i] = 1'b0; ca[i] = 8'h0; cd[i] = 32'h0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            rstep(acc, g);
            if (acc) pend[g] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) begin
                    if ($urandom_range(0, 15) == 0) pend[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    cw[i] = 1'($urandom_range(0, 1));
                    ca[i] = 8'h40 + 8'($urandom_range(0, 15) << 2);
                    cd[i] = $urandom;
                end
            end
            drive({pend[1], pend[0]}, {cw[1], cw[0]}, ca[0], ca[1], cd[0], cd[1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
